// File: rtl/sumator_cla_pipe.sv
// Pipelined, parametrised carry-lookahead adder/subtractor with valid/ready handshake.
// Define SUMATOR_SAT_EN to build signed saturation for the add-sat/sub-sat ops.
module sumator_cla_pipe #(
   parameter int WIDTH  = 16,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic                     in_cin,
   input  logic [1:0]               in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_sum,
   output logic                     out_cout,
   output logic                     out_ovf,
   output logic                     out_zero,
   output logic [WIDTH/GROUP-1:0]   out_p,
   output logic [WIDTH/GROUP-1:0]   out_g,
   output logic [WIDTH/GROUP-1:0]   out_c
);

   localparam int NG   = WIDTH / GROUP;
   localparam int NRES = (STAGES > 1) ? STAGES - 1 : 1;

   if (GROUP < 1 || WIDTH % GROUP != 0) begin : g_bad_width
      $error("sumator_cla_pipe: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("sumator_cla_pipe: STAGES (%0d) must be in 1..4", STAGES);
   end

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;    // already inverted for subtract ops
      logic             cin;
`ifdef SUMATOR_SAT_EN
      logic             sat;
`endif
      logic [NG-1:0]    gp;
      logic [NG-1:0]    gg;
   } front_t;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
      logic [NG-1:0]    p;
      logic [NG-1:0]    g;
      logic [NG-1:0]    c;
   } res_t;

   function automatic front_t do_front(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic             cin,
                                       input logic             sub);
      front_t           f;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      f.a   = a;
      f.b   = sub ? ~b : b;
      f.cin = cin;
`ifdef SUMATOR_SAT_EN
      f.sat = 1'b0;
`endif
      p = f.a ^ f.b;
      g = f.a & f.b;
      for (int j = 0; j < NG; j++) begin
         f.gp[j] = &p[j*GROUP +: GROUP];
         f.gg[j] = 1'b0;
         for (int i = 0; i < GROUP; i++)
            f.gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & f.gg[j]);
      end
      return f;
   endfunction

   function automatic res_t do_back(input front_t f);
      res_t             r;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      logic [NG:0]      c;
      logic             term;
      logic             cb;
      p = f.a ^ f.b;
      g = f.a & f.b;
      // Flattened lookahead: every group carry is a sum of products of lower-group P/G and cin.
      for (int j = 0; j <= NG; j++) begin
         c[j] = f.cin;
         for (int k = 0; k < j; k++) c[j] = c[j] & f.gp[k];
         for (int k = 0; k < j; k++) begin
            term = f.gg[k];
            for (int m = k + 1; m < j; m++) term = term & f.gp[m];
            c[j] = c[j] | term;
         end
      end
      r.sum = '0;
      for (int j = 0; j < NG; j++) begin
         cb = c[j];
         for (int i = 0; i < GROUP; i++) begin
            r.sum[j*GROUP+i] = p[j*GROUP+i] ^ cb;
            cb = g[j*GROUP+i] | (p[j*GROUP+i] & cb);
         end
      end
      r.cout = c[NG];
      r.ovf  = (f.a[WIDTH-1] == f.b[WIDTH-1]) && (r.sum[WIDTH-1] != f.a[WIDTH-1]);
`ifdef SUMATOR_SAT_EN
      if (f.sat && r.ovf)
         r.sum = f.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      r.zero = (r.sum == '0);
      r.p    = f.gp;
      r.g    = f.gg;
      r.c    = c[NG-1:0];
      return r;
   endfunction

   logic              stall;
   front_t            f_in;
   res_t              res_in;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] vld_d;
   res_t              res_q [NRES];
   res_t              res_d [NRES];

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   always_comb begin
      f_in = do_front(in_a, in_b, in_cin, in_op[0]);
`ifdef SUMATOR_SAT_EN
      f_in.sat = in_op[1];
`endif
   end

`ifndef SUMATOR_SAT_EN
   logic unused_sat_op;
   assign unused_sat_op = in_op[1];
`endif

   if (STAGES == 1) begin : g_single
      always_comb res_in = do_back(f_in);
   end else begin : g_split
      front_t front_q;
      front_t front_d;

      always_comb front_d = stall ? front_q : f_in;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) front_q <= '0;
         else     front_q <= front_d;
      end

      always_comb res_in = do_back(front_q);
   end

   // Empty slots advance like real beats; the whole pipe freezes only on output stall.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      vld_d = vld_q;
      res_d = res_q;
      if (!stall) begin
         vld_d[0] = in_valid;
         res_d[0] = res_in;
         for (int s = 1; s < STAGES; s++) vld_d[s] = vld_q[s-1];
         for (int s = 1; s < NRES; s++)   res_d[s] = res_q[s-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         res_q <= '{default: '0};
      end else begin
         vld_q <= vld_d;
         res_q <= res_d;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_sum   = res_q[NRES-1].sum;
   assign out_cout  = res_q[NRES-1].cout;
   assign out_ovf   = res_q[NRES-1].ovf;
   assign out_zero  = res_q[NRES-1].zero;
   assign out_p     = res_q[NRES-1].p;
   assign out_g     = res_q[NRES-1].g;
   assign out_c     = res_q[NRES-1].c;

endmodule

// File: tb/tb_sumator_cla_pipe.sv
// Self-checking bench for sumator_cla_pipe: a 16/4/2 instance and a 32/8/3 instance.
// Expected values come from a plain-arithmetic model; SUMATOR_SAT_EN selects saturating expectations.
module tb_sumator_cla_pipe;

`ifdef SUMATOR_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic [7:0]  p;
      logic [7:0]  g;
      logic [7:0]  c;
      int          acc;
      bit          lat;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [1:0]  op;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      bit          pgc;
      logic [3:0]  p;
      logic [3:0]  g;
      logic [3:0]  c;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        cin_s;
   logic [1:0]  op_s;
   logic        out_ready;
   logic        v16, rdy16, ov16, cout16, ovf16, zero16;
   logic [15:0] a16, b16, sum16;
   logic [3:0]  p16, g16, c16;
   logic        v32, rdy32, ov32, cout32, ovf32, zero32;
   logic [31:0] a32, b32, sum32;
   logic [3:0]  p32, g32, c32;

   int   errors = 0;
   int   n_checks = 0;
   int   cyc = 0;
   bit   sel = 1'b0;
   exp_t q16[$];
   exp_t q32[$];
   vec_t tv[9];

   sumator_cla_pipe dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_a(a16), .in_b(b16),
      .in_cin(cin_s), .in_op(op_s), .out_valid(ov16), .out_ready(out_ready),
      .out_sum(sum16), .out_cout(cout16), .out_ovf(ovf16), .out_zero(zero16),
      .out_p(p16), .out_g(g16), .out_c(c16)
   );

   sumator_cla_pipe #(.WIDTH(32), .GROUP(8), .STAGES(3)) dut32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_a(a32), .in_b(b32),
      .in_cin(cin_s), .in_op(op_s), .out_valid(ov32), .out_ready(out_ready),
      .out_sum(sum32), .out_cout(cout32), .out_ovf(ovf32), .out_zero(zero32),
      .out_p(p32), .out_g(g32), .out_c(c32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: whole-word arithmetic; group P/G/carries derived from sums, not gate equations.
   function automatic exp_t model(input int w, input int grp, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input logic cin, input logic [1:0] op);
      exp_t        e;
      logic [63:0] mask, a, bb, full, cv, gm;
      mask   = (64'd1 << w) - 64'd1;
      a      = a_in & mask;
      bb     = (op[0] ? ~b_in : b_in) & mask;
      full   = a + bb + {63'd0, cin};
      cv     = full ^ a ^ bb;
      e.sum  = 32'(full & mask);
      e.cout = full[w];
      e.ovf  = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
      if (SAT && op[1] && e.ovf)
         e.sum = a[w-1] ? (32'd1 << (w-1)) : ((32'd1 << (w-1)) - 32'd1);
      e.zero = (e.sum == 32'd0);
      gm  = (64'd1 << grp) - 64'd1;
      e.p = '0;
      e.g = '0;
      e.c = '0;
      for (int j = 0; j < w / grp; j++) begin
         e.p[j] = (((a ^ bb) >> (j*grp)) & gm) == gm;
         e.g[j] = ((((a >> (j*grp)) & gm) + ((bb >> (j*grp)) & gm)) >> grp) != 64'd0;
         e.c[j] = cv[j*grp];
      end
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   task automatic compare(input string tag, input exp_t e, input logic [31:0] sum,
                          input logic cout, input logic ovf, input logic zero,
                          input logic [7:0] p, input logic [7:0] g, input logic [7:0] c,
                          input int stages);
      check({tag, "_sum"}, 64'(sum), 64'(e.sum));
      check({tag, "_cout"}, 64'(cout), 64'(e.cout));
      check({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
      check({tag, "_zero"}, 64'(zero), 64'(e.zero));
      check({tag, "_p"}, 64'(p), 64'(e.p));
      check({tag, "_g"}, 64'(g), 64'(e.g));
      check({tag, "_c"}, 64'(c), 64'(e.c));
      if (e.lat) check({tag, "_latency"}, 64'(cyc - e.acc), 64'(stages));
   endtask

   // Output monitors: sample mid-low-phase, the values that the next rising edge will act on.
   logic [15:0] h_sum;
   logic [2:0]  h_flags;
   logic [3:0]  h_c;
   bit          held_v = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      #3;
      check("in_ready16", 64'(rdy16), 64'(!(ov16 && !out_ready)));
      if (held_v) begin
         check("hold_valid16", 64'(ov16), 64'd1);
         check("hold_sum16", 64'(sum16), 64'(h_sum));
         check("hold_flags16", 64'({cout16, ovf16, zero16}), 64'(h_flags));
         check("hold_c16", 64'(c16), 64'(h_c));
      end
      held_v  = ov16 && !out_ready;
      h_sum   = sum16;
      h_flags = {cout16, ovf16, zero16};
      h_c     = c16;
      if (ov16 && out_ready) begin
         if (q16.size() == 0) begin
            n_checks++;
            errors++;
            $display("FAIL out16_unexpected: got result 0x%0h, want none pending", sum16);
         end else begin
            e = q16.pop_front();
            compare("out16", e, 32'(sum16), cout16, ovf16, zero16, 8'(p16), 8'(g16), 8'(c16), 2);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      #3;
      if (ov32 && out_ready) begin
         if (q32.size() == 0) begin
            n_checks++;
            errors++;
            $display("FAIL out32_unexpected: got result 0x%0h, want none pending", sum32);
         end else begin
            e = q32.pop_front();
            compare("out32", e, sum32, cout32, ovf32, zero32, 8'(p32), 8'(g32), 8'(c32), 3);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         v16 = 1'b0;
         v32 = 1'b0;
      end
   endtask

   // Presents a beat and holds it until accepted; valid stays up until the next call or idle().
   task automatic send_exp(input logic [63:0] a, input logic [63:0] b, input logic cin,
                           input logic [1:0] op, input exp_t e_in);
      exp_t e;
      int   waited;
      e = e_in;
      @(negedge clk);
      cin_s = cin;
      op_s  = op;
      if (sel) begin
         a32 = a[31:0]; b32 = b[31:0]; v32 = 1'b1; v16 = 1'b0;
      end else begin
         a16 = a[15:0]; b16 = b[15:0]; v16 = 1'b1; v32 = 1'b0;
      end
      waited = 0;
      #1;
      while (!(sel ? rdy32 : rdy16)) begin
         if (waited == 100) begin
            n_checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
            v16 = 1'b0;
            v32 = 1'b0;
            return;
         end
         @(negedge clk);
         #1;
         waited++;
      end
      e.acc = cyc;
      if (sel) q32.push_back(e);
      else     q16.push_back(e);
   endtask

   function automatic logic [63:0] pick(input int w);
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'd1 << (w-1);
         3:       return (64'd1 << (w-1)) - 64'd1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic send_rand(input bit lat);
      logic [63:0] a, b;
      logic        cin;
      logic [1:0]  op;
      exp_t        e;
      a   = pick(sel ? 32 : 16);
      b   = pick(sel ? 32 : 16);
      cin = 1'($urandom_range(0, 1));
      op  = 2'($urandom_range(0, 3));
      e   = model(sel ? 32 : 16, sel ? 8 : 4, a, b, cin, op);
      e.lat = lat;
      send_exp(a, b, cin, op, e);
   endtask

   task automatic rand_phase(input int n);
      bit done;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               send_rand(1'b0);
               if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      idle(8);
   endtask

   // Reset with beats in flight: everything clears at once, then a fresh beat has normal latency.
   task automatic reset_test(input string tag, input int stages);
      for (int k = 0; k < 3; k++) send_rand(1'b0);
      @(negedge clk);
      v16 = 1'b0;
      v32 = 1'b0;
      rst = 1'b1;
      #1;
      if (sel) begin
         check({tag, "_rst_valid"}, 64'(ov32), 64'd0);
         check({tag, "_rst_out"}, 64'({sum32, cout32, ovf32, zero32, p32, g32, c32}), 64'd0);
         check({tag, "_rst_ready"}, 64'(rdy32), 64'd1);
      end else begin
         check({tag, "_rst_valid"}, 64'(ov16), 64'd0);
         check({tag, "_rst_out"}, 64'({sum16, cout16, ovf16, zero16, p16, g16, c16}), 64'd0);
         check({tag, "_rst_ready"}, 64'(rdy16), 64'd1);
      end
      q16.delete();
      q32.delete();
      @(negedge clk);
      rst = 1'b0;
      send_rand(1'b1);
      idle(stages + 3);
      check({tag, "_post_rst_drained"}, 64'(sel ? q32.size() : q16.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      exp_t e;
      tv[0] = '{16'hCAE6, 16'hDCC3, 1'b1, 2'b00, 16'hA7AA, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
      tv[1] = '{16'hCAE2, 16'hDCCB, 1'b0, 2'b00, 16'hA7AD, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
      tv[2] = '{16'hFFFF, 16'h0000, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF};
      tv[3] = '{16'h0005, 16'h0007, 1'b1, 2'b01, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
      tv[4] = '{16'h8000, 16'h0001, 1'b1, 2'b01, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
      tv[5] = '{16'h7FFF, 16'h0001, 1'b0, 2'b10, SAT ? 16'h7FFF : 16'h8000,
                1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
      tv[6] = '{16'h8000, 16'h0001, 1'b1, 2'b11, SAT ? 16'h8000 : 16'h7FFF,
                1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
      tv[7] = '{16'h1234, 16'h1234, 1'b1, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
      tv[8] = '{16'h0001, 16'h0002, 1'b0, 2'b10, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};

      rst = 1'b0; out_ready = 1'b1; cin_s = 1'b0; op_s = 2'b00;
      v16 = 1'b0; a16 = '0; b16 = '0;
      v32 = 1'b0; a32 = '0; b32 = '0;
      #1 rst = 1'b1;
      #1;
      check("reset_valid16", 64'(ov16), 64'd0);
      check("reset_out16", 64'({sum16, cout16, ovf16, zero16, p16, g16, c16}), 64'd0);
      check("reset_ready16", 64'(rdy16), 64'd1);
      check("reset_valid32", 64'(ov32), 64'd0);
      check("reset_out32", 64'({sum32, cout32, ovf32, zero32, p32, g32, c32}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors, back-to-back, each checked for exact latency.
      for (int i = 0; i < 9; i++) begin
         e = model(16, 4, 64'(tv[i].a), 64'(tv[i].b), tv[i].cin, tv[i].op);
         e.sum  = 32'(tv[i].sum);
         e.cout = tv[i].cout;
         e.ovf  = tv[i].ovf;
         e.zero = tv[i].zero;
         if (tv[i].pgc) begin
            e.p = 8'(tv[i].p);
            e.g = 8'(tv[i].g);
            e.c = 8'(tv[i].c);
         end
         e.lat = 1'b1;
         send_exp(64'(tv[i].a), 64'(tv[i].b), tv[i].cin, tv[i].op, e);
      end
      idle(5);

      // Eight-beat stream with a three-cycle downstream stall in the middle.
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand(1'b0);
            idle(1);
         end
         begin
            repeat (4) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) begin
               #1;
               check("stall_valid16", 64'(ov16), 64'd1);
               check("stall_in_ready16", 64'(rdy16), 64'd0);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      idle(6);
      check("stream_none_lost16", 64'(q16.size()), 64'd0);

      rand_phase(150);
      reset_test("r16", 2);

      sel = 1'b1;
      rand_phase(100);
      reset_test("r32", 3);

      idle(8);
      check("final_drained16", 64'(q16.size()), 64'd0);
      check("final_drained32", 64'(q32.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sumator_cla_pipe.md
Name: sumator_cla_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor, successor to the fixed 16-bit combinational sumator16b.
- Generalised in operand width, lookahead group size and pipeline depth.
- Adds subtract mode, signed overflow/zero flags and a valid/ready handshake with backpressure.
- Sits between operand sources and the ALU result bus; exports per-group P/G/C for debug, as the 16-bit block did.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of GROUP.
GROUP, 4, bits per lookahead group; NG = WIDTH/GROUP groups.
STAGES, 2, pipeline latency in cycles; legal range 1..4.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry in
in_op  in  2  00 add, 01 sub, 10 add-sat, 11 sub-sat
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  WIDTH  result
out_cout  out  1  carry out of MSB
out_ovf  out  1  signed overflow of the unsaturated result
out_zero  out  1  out_sum == 0
out_p  out  NG  group propagate
out_g  out  NG  group generate
out_c  out  NG  carry into each group; out_c[0] = effective cin

Behaviour:
- Reset is asynchronous and active-high: rst high clears all stage valid bits and all output registers to 0 immediately. in_ready reads 1 while out_valid = 0.
- Arithmetic:
  - add: A + B + cin.
  - sub: A + ~B + cin. cin=1 gives A-B; cin=0 gives A-B-1.
  - cout is the raw carry; for sub, cout=0 means borrow.
  - ovf = (opA_msb == opB'_msb) && (sum_msb != opA_msb), where B' is B or ~B.
- Lookahead: per-group P = AND of bit propagates, G = group generate. Carries between groups are computed by a lookahead unit over NG groups, never by ripple across groups.
- Transfer and latency:
  - A beat transfers when in_valid && in_ready.
  - Its result appears on out_* exactly STAGES cycles later if the output is not stalled.
  - STAGES=1: single register after the full combinational CLA.
  - STAGES≥2: stage 1 registers the operands plus group P/G/cin; the group carry/sum is computed in a later stage; any extra stages are delay registers.
- Handshake:
  - stall = out_valid && !out_ready; in_ready = !stall.
  - During stall every stage holds its contents; no beat is dropped or duplicated.
  - out_* stay stable while out_valid && !out_ready.
- Bubbles:
  - in_valid=0 inserts an empty slot.
  - Empty slots still advance. There is no bubble collapse; throughput is 1 beat/cycle when out_ready=1.
- Back-to-back: a new beat can be accepted in the same cycle the output transfers.
- Reset mid-operation: all in-flight beats are discarded, with no partial result.
- Width rules: WIDTH % GROUP != 0 or STAGES outside 1..4 must cause an elaboration-time error.

Optional Feature:
Macro SUMATOR_SAT_EN.
- Defined: ops 10/11 saturate on signed overflow.
  - Positive overflow gives 0111..1; negative overflow gives 1000..0.
  - out_ovf is still reported, and out_zero reflects the saturated out_sum.
- Undefined: ops 10/11 behave exactly as 00/01 and no saturation logic is built.

Test Plan:
1. STAGES=2, add, a=0xCAE6, b=0xDCC3, cin=1 -> 2 cycles later: sum=0xA7AA, cout=1, ovf=0, zero=0. Next beat a=0xCAE2, b=0xDCCB, cin=0 -> sum=0xA7AD, cout=1, one cycle after the first result.
2. add, a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, out_p=4'hF, out_g=4'h0, out_c=4'hF.
3. sub, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, cin=1 -> sum=0x7FFF, ovf=1.
4. add-sat, a=0x7FFF, b=0x0001, cin=0 -> with SUMATOR_SAT_EN: sum=0x7FFF, ovf=1. Without the macro: sum=0x8000, ovf=1.
5. Stream 8 beats with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, out_* held stable, all 8 results in order, none lost.
6. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and all outputs 0 immediately. The first beat after reset returns correctly after STAGES cycles. Repeat with WIDTH=32, GROUP=8, STAGES=3.
